ristretto_shift_ctrl: RTL

- Execute-stage sequencer that sits directly upstream of ristretto_shift_unit.
- Accepts one shift micro-op per transaction from the exe control path over a valid/ready handshake.
- Resolves 0- and 1-bit shifts itself in one cycle. For amounts of 2 or more, it drives the multi-cycle shift unit, counts its shifts, and captures the result.
- Presents the result and destination tag downstream over a valid/ready handshake, and stalls upstream while busy.

---
 rtl/ristretto_exe_stage_pkg.sv | 27 ++
 rtl/ristretto_shift_fastpath.sv | 28 ++
 rtl/ristretto_shift_ctrl.sv | 134 +++++++++++++
 3 files changed

// File: rtl/ristretto_exe_stage_pkg.sv
// Shared exe-stage definitions: shift modes, fast-path limit and the
// shift controller state encoding.
package ristretto_exe_stage_pkg;

  localparam logic [1:0] SHIFT_LEFT    = 2'b00;
  localparam logic [1:0] SHIFT_RIGHT   = 2'b01;
  localparam logic [1:0] SHIFT_ARIGHT  = 2'b10;
  localparam logic [1:0] SHIFT_ILLEGAL = 2'b11;

  localparam int SHAMT_W        = 5;
  localparam int SHAMT_FAST_MAX = 1;

  typedef enum logic [1:0] {
    SHCTL_IDLE = 2'd0,
    SHCTL_RUN  = 2'd1,
    SHCTL_CAPT = 2'd2,
    SHCTL_OUT  = 2'd3
  } shift_ctrl_state_t;

  // An op never needs the shift unit when it moves by at most one bit or
  // carries the illegal mode (which passes the operand through).
  function automatic logic is_fast_op(input logic [SHAMT_W-1:0] shamt,
                                      input logic [1:0]         mode);
    return (int'(shamt) <= SHAMT_FAST_MAX) || (mode == SHIFT_ILLEGAL);
  endfunction

endpackage

// File: rtl/ristretto_shift_fastpath.sv
// Combinational 0/1-bit shifter shared by exe-stage consumers.
module ristretto_shift_fastpath
  import ristretto_exe_stage_pkg::*;
#(
  parameter int DataWidth = 32
) (
  input  logic [DataWidth-1:0] operand_a,
  input  logic [SHAMT_W-1:0]   shamt,
  input  logic [1:0]           mode,
  output logic                 fast,
  output logic [DataWidth-1:0] result
);

  // Shift by one when asked; shamt 0 and the illegal mode pass through.
  always_comb begin
    fast   = is_fast_op(shamt, mode);
    result = operand_a;
    if (shamt == SHAMT_W'(1)) begin
      case (mode)
        SHIFT_LEFT:   result = {operand_a[DataWidth-2:0], 1'b0};
        SHIFT_RIGHT:  result = {1'b0, operand_a[DataWidth-1:1]};
        SHIFT_ARIGHT: result = {operand_a[DataWidth-1], operand_a[DataWidth-1:1]};
        default:      result = operand_a;
      endcase
    end
  end

endmodule

// File: rtl/ristretto_shift_ctrl.sv
// Execute-stage shift sequencer in front of ristretto_shift_unit.
//
//   state | meaning
//   ------+--------------------------------------------------------------
//   IDLE  | ready for a new op; fast ops go straight to OUT
//   RUN   | shift unit enabled, one bit per cycle, counter tracks shifts
//   CAPT  | enable dropped so the unit clears; result captured at the edge
//   OUT   | result/tag held until the consumer takes them
module ristretto_shift_ctrl
  import ristretto_exe_stage_pkg::*;
#(
  parameter int DataWidth = 32,
  parameter int TagWidth  = 5
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 flush_i,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [DataWidth-1:0] in_operand_a_i,
  input  logic [SHAMT_W-1:0]   in_shamt_i,
  input  logic [1:0]           in_mode_i,
  input  logic [TagWidth-1:0]  in_tag_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [DataWidth-1:0] out_result_o,
  output logic [TagWidth-1:0]  out_tag_o,
  output logic [DataWidth-1:0] shu_operand_a_o,
  output logic [SHAMT_W-1:0]   shu_operand_b_o,
  output logic [1:0]           shu_mode_o,
  output logic                 shu_en_o,
  input  logic                 shu_busy_i,
  input  logic [DataWidth-1:0] shu_result_i
);

  shift_ctrl_state_t    state_q;
  logic [SHAMT_W-1:0]   cnt_q;
  logic [DataWidth-1:0] operand_a_q;
  logic [SHAMT_W-1:0]   shamt_q;
  logic [1:0]           mode_q;
  logic [TagWidth-1:0]  tag_q;
  logic [DataWidth-1:0] result_q;

  logic                 accept;
  logic                 fast_sel;
  logic [DataWidth-1:0] fast_result;

  ristretto_shift_fastpath #(
    .DataWidth (DataWidth)
  ) u_fastpath (
    .operand_a (in_operand_a_i),
    .shamt     (in_shamt_i),
    .mode      (in_mode_i),
    .fast      (fast_sel),
    .result    (fast_result)
  );

  assign in_ready_o      = (state_q == SHCTL_IDLE);
  assign accept          = in_valid_i & in_ready_o;
  assign out_valid_o     = (state_q == SHCTL_OUT);
  assign shu_en_o        = (state_q == SHCTL_RUN);
  assign out_result_o    = result_q;
  assign out_tag_o       = tag_q;
  assign shu_operand_a_o = operand_a_q;
  assign shu_operand_b_o = shamt_q;
  assign shu_mode_o      = mode_q;

  // State and shift counter; reset beats flush, flush beats everything else.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= SHCTL_IDLE;
      cnt_q   <= '0;
    end else if (flush_i) begin
      state_q <= SHCTL_IDLE;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        SHCTL_IDLE: begin
          if (in_valid_i) begin
            cnt_q   <= '0;
            state_q <= fast_sel ? SHCTL_OUT : SHCTL_RUN;
          end
        end
        SHCTL_RUN: begin
          cnt_q <= cnt_q + SHAMT_W'(1);
          // Leaving on shamt-1 gives exactly shamt enabled cycles.
          if (cnt_q == shamt_q - SHAMT_W'(1)) begin
            state_q <= SHCTL_CAPT;
          end
        end
        SHCTL_CAPT: begin
          state_q <= SHCTL_OUT;
        end
        SHCTL_OUT: begin
          if (out_ready_i) begin
            state_q <= SHCTL_IDLE;
          end
        end
        default: begin
          state_q <= SHCTL_IDLE;
        end
      endcase
    end
  end

  // Op registers load on accept; the result loads from the fast path on
  // accept or from the shift unit in CAPT. A flush simply abandons them.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      operand_a_q <= '0;
      shamt_q     <= '0;
      mode_q      <= '0;
      tag_q       <= '0;
      result_q    <= '0;
    end else if (!flush_i) begin
      if (accept) begin
        operand_a_q <= in_operand_a_i;
        shamt_q     <= in_shamt_i;
        mode_q      <= in_mode_i;
        tag_q       <= in_tag_i;
        if (fast_sel) begin
          result_q <= fast_result;
        end
      end else if (state_q == SHCTL_CAPT) begin
        result_q <= shu_result_i;
      end
    end
  end

  // The shift unit must report busy from the second enabled cycle onward.
  busy_in_run_a : assert property (@(posedge clk_i) disable iff (rst_i)
    (state_q == SHCTL_RUN && cnt_q != '0) |-> shu_busy_i);

endmodule
